// File: rtl/oflow_score_board.sv
// oflow_score_board
// Responder side of the registration score-board handshake. A one-cycle
// start_score_board captures one set of per-slot match results. The block then
// scans the set one slot per cycle. Each valid object gets one of two IDs:
//   - its matched previous-frame ID, if that candidate is good enough and not
//     already claimed in this set;
//   - otherwise a fresh ID from a counter that persists across sets.
// Each assignment is presented on the wr_* write port for the ID buffer.
// A one-cycle done_score_board closes the set.
//
// Ports
//   clk, reset_N           clock, async active-low reset
//   start_score_board      start pulse (IDLE only)
//   first_frame            1 = no matching, every valid slot gets a fresh ID
//   set_idx                set being registered
//   valid_in               per-slot valid mask
//   scores_in              per-slot best score, slot k at [k*SCORE_W +: SCORE_W]
//   cand_id_in             per-slot candidate previous-frame ID
//   score_thresh           match threshold (score <= thresh matches)
//   clear_ids              clears fresh-ID counter and overflow flag (IDLE only)
//   busy                   high in SCAN and DONE
//   wr_en/wr_addr/wr_id/wr_new  ID-buffer write port, addr = {set_idx, slot}
//   done_score_board       completion pulse
//   next_id                next fresh ID to issue
//   id_overflow            sticky: fresh-ID space exhausted
module oflow_score_board #(
  parameter int NUM_PE  = 4,
  parameter int SCORE_W = 16,
  parameter int ID_W    = 8,
  parameter int SET_LEN = 4
) (
  input  logic                               clk,
  input  logic                               reset_N,
  input  logic                               start_score_board,
  input  logic                               first_frame,
  input  logic [SET_LEN-1:0]                 set_idx,
  input  logic [NUM_PE-1:0]                  valid_in,
  input  logic [NUM_PE*SCORE_W-1:0]          scores_in,
  input  logic [NUM_PE*ID_W-1:0]             cand_id_in,
  input  logic [SCORE_W-1:0]                 score_thresh,
  input  logic                               clear_ids,
  output logic                               busy,
  output logic                               wr_en,
  output logic [SET_LEN+$clog2(NUM_PE)-1:0]  wr_addr,
  output logic [ID_W-1:0]                    wr_id,
  output logic                               wr_new,
  output logic                               done_score_board,
  output logic [ID_W-1:0]                    next_id,
  output logic                               id_overflow
);
  localparam int SLOT_W = $clog2(NUM_PE);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, state_nx;

  logic [SLOT_W-1:0]                slot;
  logic                             ff_q;
  logic [SET_LEN-1:0]               set_q;
  logic [NUM_PE-1:0]                valid_q;
  logic [NUM_PE-1:0][SCORE_W-1:0]   scores_q;
  logic [NUM_PE-1:0][ID_W-1:0]      cand_q;
  logic [SCORE_W-1:0]               thresh_q;

  // Claimed list: entry k holds the ID matched at slot k in this set.
  logic [NUM_PE-1:0][ID_W-1:0]      claim_id;
  logic [NUM_PE-1:0]                claim_vld;
  logic [NUM_PE-1:0]                claim_hit;

  logic [SCORE_W-1:0]               cur_score;
  logic [ID_W-1:0]                  cur_cand;
  logic                             match;
  logic                             fresh;

  assign cur_score = scores_q[slot];
  assign cur_cand  = cand_q[slot];

  for (genvar k = 0; k < NUM_PE; k++) begin : g_claim
    assign claim_hit[k] = claim_vld[k] && (claim_id[k] == cur_cand);
  end

  // Earlier slots have already entered the list, so lower index wins a duplicate.
  assign match = !ff_q && (cur_score <= thresh_q) && !(|claim_hit);
  assign fresh = wr_en && !match;

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx         = state;
    busy             = 1'b0;
    wr_en            = 1'b0;
    wr_addr          = '0;
    wr_id            = '0;
    wr_new           = 1'b0;
    done_score_board = 1'b0;
    case (state)
      IDLE: if (start_score_board) state_nx = SCAN;
      SCAN: begin
        busy = 1'b1;
        if (valid_q[slot]) begin
          wr_en   = 1'b1;
          wr_addr = {set_q, slot};
          wr_id   = match ? cur_cand : next_id;
          wr_new  = !match;
        end
        if (slot == SLOT_W'(NUM_PE - 1)) state_nx = DONE;
      end
      DONE: begin
        busy             = 1'b1;
        done_score_board = 1'b1;
        state_nx         = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      slot        <= '0;
      ff_q        <= 1'b0;
      set_q       <= '0;
      valid_q     <= '0;
      scores_q    <= '0;
      cand_q      <= '0;
      thresh_q    <= '0;
      claim_id    <= '0;
      claim_vld   <= '0;
      next_id     <= '0;
      id_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_ids) begin
            next_id     <= '0;
            id_overflow <= 1'b0;
          end
          if (start_score_board) begin
            slot      <= '0;
            ff_q      <= first_frame;
            set_q     <= set_idx;
            valid_q   <= valid_in;
            scores_q  <= scores_in;
            cand_q    <= cand_id_in;
            thresh_q  <= score_thresh;
            claim_vld <= '0;
          end
        end
        SCAN: begin
          slot <= slot + 1'b1;
          if (wr_en && match) begin
            claim_id[slot]  <= cur_cand;
            claim_vld[slot] <= 1'b1;
          end
          // Saturate at all-ones: the last ID is reissued rather than wrapping.
          if (fresh) begin
            if (&next_id) id_overflow <= 1'b1;
            else          next_id     <= next_id + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_oflow_score_board.sv
module tb_oflow_score_board;
  logic        clk = 1'b0;
  logic        reset_N = 1'b0;
  logic        start_score_board = 1'b0;
  logic        first_frame = 1'b0;
  logic        clear_ids = 1'b0;
  logic [3:0]  set_idx = '0;
  logic [3:0]  valid_in = '0;
  logic [63:0] scores_in = '0;
  logic [31:0] cand_id_in = '0;
  logic [15:0] score_thresh = '0;
  logic        busy, wr_en, wr_new, done_score_board, id_overflow;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_id, next_id;

  oflow_score_board dut (
    .clk(clk), .reset_N(reset_N), .start_score_board(start_score_board),
    .first_frame(first_frame), .set_idx(set_idx), .valid_in(valid_in),
    .scores_in(scores_in), .cand_id_in(cand_id_in), .score_thresh(score_thresh),
    .clear_ids(clear_ids), .busy(busy), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_id(wr_id), .wr_new(wr_new), .done_score_board(done_score_board),
    .next_id(next_id), .id_overflow(id_overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  // Reference state: fresh-ID counter and sticky overflow.
  logic [7:0] m_next = '0;
  logic       m_ovf = 1'b0;

  task automatic scramble();
    first_frame  = 1'($urandom);
    set_idx      = 4'($urandom);
    valid_in     = 4'($urandom);
    scores_in    = {$urandom, $urandom};
    cand_id_in   = $urandom;
    score_thresh = 16'($urandom);
  endtask

  // Runs one set and checks every cycle of it. disturb = re-pulse start and
  // raise clear_ids mid-scan with scrambled inputs; both must be ignored.
  task automatic do_set(input logic ff, input logic [3:0] st, input logic [3:0] vm,
                        input logic [63:0] sc, input logic [31:0] cd,
                        input logic [15:0] th, input bit disturb, input string tag);
    logic [7:0] claimed[$];
    logic [7:0] e_id[4];
    logic       e_new[4];
    logic [7:0] c;
    logic [15:0] s;
    bit hit;
    for (int k = 0; k < 4; k++) begin
      c = cd[k*8 +: 8];
      s = sc[k*16 +: 16];
      hit = 0;
      foreach (claimed[j]) if (claimed[j] == c) hit = 1;
      e_id[k] = '0;
      e_new[k] = 1'b0;
      if (vm[k]) begin
        if (!ff && s <= th && !hit) begin
          e_id[k] = c;
          claimed.push_back(c);
        end else begin
          e_id[k] = m_next;
          e_new[k] = 1'b1;
          if (m_next == 8'hFF) m_ovf = 1'b1;
          else m_next = m_next + 8'd1;
        end
      end
    end
    @(negedge clk);
    first_frame = ff; set_idx = st; valid_in = vm; scores_in = sc;
    cand_id_in = cd; score_thresh = th; start_score_board = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start_score_board = 1'b0;
      clear_ids = 1'b0;
      scramble();
      if (disturb && k == 1) begin
        start_score_board = 1'b1;
        clear_ids = 1'b1;
      end
      n_cmp++;
      if (wr_en !== vm[k] || busy !== 1'b1 || done_score_board !== 1'b0) begin
        n_err++;
        $display("FAIL %s slot%0d ctl got en=%b busy=%b done=%b exp en=%b busy=1 done=0",
                 tag, k, wr_en, busy, done_score_board, vm[k]);
      end
      if (vm[k]) begin
        n_cmp++;
        if (wr_addr !== {st, 2'(k)} || wr_id !== e_id[k] || wr_new !== e_new[k]) begin
          n_err++;
          $display("FAIL %s slot%0d write got addr=%h id=%0d new=%b exp addr=%h id=%0d new=%b",
                   tag, k, wr_addr, wr_id, wr_new, {st, 2'(k)}, e_id[k], e_new[k]);
        end
      end
    end
    @(negedge clk);
    start_score_board = 1'b0;
    clear_ids = 1'b0;
    n_cmp++;
    if (done_score_board !== 1'b1 || busy !== 1'b1 || wr_en !== 1'b0) begin
      n_err++;
      $display("FAIL %s done-cycle got done=%b busy=%b en=%b exp 1 1 0",
               tag, done_score_board, busy, wr_en);
    end
    @(negedge clk);
    n_cmp++;
    if (done_score_board !== 1'b0 || busy !== 1'b0 || next_id !== m_next || id_overflow !== m_ovf) begin
      n_err++;
      $display("FAIL %s idle got done=%b busy=%b next_id=%0d ovf=%b exp 0 0 %0d %b",
               tag, done_score_board, busy, next_id, id_overflow, m_next, m_ovf);
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({busy, wr_en, wr_addr, wr_id, wr_new, done_score_board, next_id, id_overflow} !== '0) begin
      n_err++;
      $display("FAIL reset outputs got busy=%b en=%b addr=%h id=%h new=%b done=%b next=%h ovf=%b exp all 0",
               busy, wr_en, wr_addr, wr_id, wr_new, done_score_board, next_id, id_overflow);
    end
    repeat (2) @(negedge clk);
    reset_N = 1'b1;
  endtask

  task automatic test_first_frame();
    do_set(1'b1, 4'h2, 4'hF, 64'h0003_0002_0001_0000, 32'h0102_0304, 16'd100, 0, "first_frame");
  endtask

  task automatic test_matching();
    do_set(1'b0, 4'h3, 4'hF, {16'd0, 16'd100, 16'd150, 16'd50},
           {8'd10, 8'd9, 8'd8, 8'd7}, 16'd100, 0, "matching");
  endtask

  task automatic test_duplicate();
    do_set(1'b0, 4'h4, 4'hF, 64'd0, {4{8'd3}}, 16'd0, 0, "duplicate");
  endtask

  task automatic test_invalid_slots();
    do_set(1'b0, 4'h5, 4'b0101, {16'd5, 16'd500, 16'd5, 16'd500},
           {8'd20, 8'd21, 8'd22, 8'd23}, 16'd10, 0, "invalid_slots");
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      do_set(1'($urandom_range(0, 3) == 0), 4'($urandom), 4'($urandom),
             {16'($urandom_range(0, 300)), 16'($urandom_range(0, 300)),
              16'($urandom_range(0, 300)), 16'($urandom_range(0, 300))},
             {8'($urandom_range(0, 5)), 8'($urandom_range(0, 5)),
              8'($urandom_range(0, 5)), 8'($urandom_range(0, 5))},
             16'($urandom_range(0, 200)), 0, "random");
    end
  endtask

  task automatic test_start_while_busy();
    do_set(1'b0, 4'h9, 4'hF, {16'd1, 16'd300, 16'd1, 16'd1},
           {8'd4, 8'd4, 8'd2, 8'd1}, 16'd50, 1, "start_busy");
  endtask

  task automatic test_overflow_clear();
    while (m_next < 8'd252)
      do_set(1'b1, 4'h1, 4'hF, 64'd0, 32'd0, 16'd0, 0, "fill");
    if (m_next != 8'hFF)
      do_set(1'b1, 4'h1, 4'((1 << (255 - int'(m_next))) - 1), 64'd0, 32'd0, 16'd0, 0, "fill_exact");
    do_set(1'b1, 4'h6, 4'b0011, 64'd0, 32'd0, 16'd0, 0, "overflow");
    n_cmp++;
    if (id_overflow !== 1'b1 || next_id !== 8'hFF) begin
      n_err++;
      $display("FAIL overflow_flag got ovf=%b next_id=%0d exp 1 255", id_overflow, next_id);
    end
    @(negedge clk);
    clear_ids = 1'b1;
    @(negedge clk);
    clear_ids = 1'b0;
    m_next = '0;
    m_ovf = 1'b0;
    n_cmp++;
    if (next_id !== 8'd0 || id_overflow !== 1'b0) begin
      n_err++;
      $display("FAIL clear_ids got next_id=%0d ovf=%b exp 0 0", next_id, id_overflow);
    end
  endtask

  task automatic test_mid_reset();
    do_set(1'b1, 4'h7, 4'hF, 64'd0, 32'd0, 16'd0, 0, "pre_reset");
    @(negedge clk);
    first_frame = 1'b1; set_idx = 4'h8; valid_in = 4'hF; start_score_board = 1'b1;
    @(negedge clk);
    start_score_board = 1'b0;
    @(negedge clk);
    reset_N = 1'b0;
    #1;
    m_next = '0;
    m_ovf = 1'b0;
    n_cmp++;
    if ({busy, wr_en, wr_addr, wr_id, wr_new, done_score_board, next_id, id_overflow} !== '0) begin
      n_err++;
      $display("FAIL mid_reset outputs got busy=%b en=%b addr=%h id=%h new=%b done=%b next=%h ovf=%b exp all 0",
               busy, wr_en, wr_addr, wr_id, wr_new, done_score_board, next_id, id_overflow);
    end
    repeat (2) @(negedge clk);
    reset_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (done_score_board !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL mid_reset_nodone cyc%0d got done=%b busy=%b exp 0 0", i, done_score_board, busy);
      end
    end
    do_set(1'b1, 4'hA, 4'hF, 64'd0, 32'd0, 16'd0, 0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_matching();
    test_duplicate();
    test_invalid_slots();
    test_random();
    test_start_while_busy();
    test_overflow_clear();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
